// File: rtl/decoder_sched_pkg.sv
// rtl/decoder_sched_pkg.sv - shared constants, FSM states and id width helper for decoder_sched
package decoder_sched_pkg;

    localparam int CODE_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of a requester index; never below one bit so ports stay legal
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decoder_sched_arb.sv
// rtl/decoder_sched_arb.sv - requester arbiter, round-robin when DECODER_SCHED_RR_EN is defined, else fixed priority
module decoder_sched_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
`ifdef DECODER_SCHED_RR_EN
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
`endif
    input  logic [NREQ-1:0] req_valid,
    output logic            grant_any,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] start;

`ifdef DECODER_SCHED_RR_EN
    logic [IDW-1:0] ptr_q;

    // Pointer moves to one past the winner on every accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // Search requesters starting at 'start', first valid one wins
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant     = '0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(start) + k) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/decoder_sched.sv
// rtl/decoder_sched.sv - time-shares one decoder among NREQ requesters; DECODER_SCHED_RR_EN selects round-robin
module decoder_sched
    import decoder_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DEC_LAT = 2,
    parameter int OUT_W   = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CODE_W-1:0]   req_code,
    output logic [NREQ-1:0]          req_ready,
    output logic [CODE_W-1:0]        dec_in,
    input  logic [OUT_W-1:0]         dec_out,
    input  logic                     dec_err,
    output logic                     rsp_valid,
    output logic [id_w(NREQ)-1:0]    rsp_id,
    output logic [OUT_W-1:0]         rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int IDW   = id_w(NREQ);
    localparam int CNT_W = $clog2(DEC_LAT + 1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                arb_en;
    logic                accept;
    logic                grant_any;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic [CODE_W-1:0]   code_sel;

    assign arb_en    = (state_q == ST_IDLE) && !wb_rst_i;
    assign accept    = arb_en && grant_any;
    assign req_ready = arb_en ? grant : '0;
    assign busy      = (state_q != ST_IDLE);

    decoder_sched_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
`ifdef DECODER_SCHED_RR_EN
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .advance   (accept),
`endif
        .req_valid (req_valid),
        .grant_any (grant_any),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    // Pick the winning requester's code word
    always_comb begin
        code_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                code_sel = req_code[i*CODE_W +: CODE_W];
            end
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: issue, wait out decoder latency, hold response until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: decoder input, id, latency counter and response capture
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            dec_in    <= '0;
            rsp_id    <= '0;
            cnt_q     <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dec_in <= code_sel;
                        rsp_id <= grant_id;
                        cnt_q  <= CNT_W'(DEC_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_data  <= dec_out;
                        rsp_err   <= dec_err;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_sched.sv
// tb/tb_decoder_sched.sv - directed and randomized bench for decoder_sched against a transaction-level model
module tb_decoder_sched;

    localparam int NREQ    = 4;
    localparam int DEC_LAT = 2;
    localparam int OUT_W   = 4;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*7-1:0]    req_code = '0;
    logic [NREQ-1:0]      req_ready;
    logic [6:0]           dec_in;
    logic [OUT_W-1:0]     dec_out;
    logic                 dec_err;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [OUT_W-1:0]     rsp_data;
    logic                 rsp_err;
    logic                 rsp_ready = 1'b1;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    decoder_sched #(
        .NREQ    (NREQ),
        .DEC_LAT (DEC_LAT),
        .OUT_W   (OUT_W)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .dec_err   (dec_err),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    assign dec_out = dec_in[6:3];
    assign dec_err = ^dec_in;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // Transaction-level model: one request in flight, response due DEC_LAT+1 cycles after accept
    bit              m_busy = 1'b0;
    int              m_acc = 0;
    int              m_id = 0;
    int              m_ptr = 0;
    int              cyc = 0;
    logic [6:0]      m_code = '0;
    logic [6:0]      m_last = '0;
    logic [NREQ-1:0] m_granted = '0;

    always @(negedge clk) begin : model_blk
        logic [NREQ-1:0] e_ready;
        logic            e_rv;
        int              w;
        int              start;
`ifdef DECODER_SCHED_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        e_rv    = m_busy && (cyc >= m_acc + DEC_LAT + 1);
        e_ready = '0;
        w       = -1;
        if (!m_busy && !rst) begin
            w = pick(req_valid, start);
            if (w >= 0) e_ready[w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("dec_in", 32'(dec_in), 32'(m_last));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_code[6:3]));
            chk("rsp_err", 32'(rsp_err), 32'(^m_code));
        end
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_last = '0;
        end else if (w >= 0) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_id   = w;
            m_code = req_code[w*7 +: 7];
            m_last = m_code;
            m_ptr  = (w + 1) % NREQ;
        end else if (e_rv && rsp_ready) begin
            m_busy = 1'b0;
        end
        m_granted = e_ready;
        cyc++;
    end

`ifdef DECODER_SCHED_RR_EN
    localparam int NG = 5;
    int exp_g[NG] = '{0, 1, 2, 3, 0};
`else
    localparam int NG = 3;
    int exp_g[NG] = '{0, 0, 0};
`endif

    int gid[$];
    int gcyc[$];
    bit seen;

    initial begin
        // reset: no grant while reset is high, outputs at reset values
        tick();
        req_valid = '1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        #2;
        chk("rst_dec_in", 32'(dec_in), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = '0;

        // single request from requester 0
        tick();
        req_valid = 4'b0001;
        req_code[6:0] = 7'b1001101;
        #2;
        chk("single_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        #2;
        chk("single_dec_in", 32'(dec_in), 32'b1001101);
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        tick();
        #2;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h0);
        chk("single_rsp_data", 32'(rsp_data), 32'h9);
        chk("single_rsp_err", 32'(rsp_err), 32'h0);
        tick();
        #2;
        chk("single_done_valid", 32'(rsp_valid), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h0);

        // parity error from requester 2
        tick();
        req_valid = 4'b0100;
        req_code[20:14] = 7'b1001100;
        #2;
        chk("parity_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();
        #2;
        chk("parity_rsp_id", 32'(rsp_id), 32'h2);
        chk("parity_rsp_data", 32'(rsp_data), 32'h9);
        chk("parity_rsp_err", 32'(rsp_err), 32'h1);
        tick();

        // contention: everyone valid continuously from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 40 && gid.size() < NG; c++) begin
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    gid.push_back(i);
                    gcyc.push_back(c);
                end
            end
            tick();
        end
        chk("contention_count", 32'(gid.size()), 32'(NG));
        for (int k = 0; k < gid.size() && k < NG; k++) begin
            chk("contention_grant", 32'(gid[k]), 32'(exp_g[k]));
            if (k > 0) chk("contention_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(DEC_LAT + 2));
        end
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // wrap: last grant to 3, then 0 and 3 both request
        req_valid = 4'b1000;
        #2;
        chk("wrap_first", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        req_valid = 4'b1001;
        #2;
        chk("wrap_second", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // backpressure with requester 1 pending
        req_valid = 4'b0001;
        req_code[6:0] = 7'b1001101;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0010;
        req_code[13:7] = 7'b0110011;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #2;
            if (rsp_valid) seen = 1'b1;
            else tick();
        end
        chk("bp_rsp_seen", 32'(seen), 32'h1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id", 32'(rsp_id), 32'h0);
            chk("bp_data", 32'(rsp_data), 32'h9);
            chk("bp_err", 32'(rsp_err), 32'h0);
            chk("bp_ready_blocked", 32'(req_ready), 32'h0);
            if (k < 4) begin
                tick();
                #2;
            end
        end
        tick();
        rsp_ready = 1'b1;
        #2;
        chk("bp_handshake_ready", 32'(req_ready), 32'h0);
        tick();
        #2;
        chk("bp_req1_accept", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();

        // reset while waiting on the decoder
        req_valid = 4'b0001;
        req_code[6:0] = 7'b1111000;
        #2;
        chk("rw_accept", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rw_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rw_dec_in", 32'(dec_in), 32'h0);
        chk("rw_busy", 32'(busy), 32'h0);
        chk("rw_rsp_id", 32'(rsp_id), 32'h0);
        chk("rw_rsp_data", 32'(rsp_data), 32'h0);
        chk("rw_rsp_err", 32'(rsp_err), 32'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            #2;
            chk("rw_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !m_granted[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    req_code[i*7 +: 7] = 7'($urandom);
                end
            end
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_sched.md
# decoder_sched

Request scheduler that time-shares one 7-bit decoder datapath among `NREQ` requesters. Each requester offers a 7-bit code word with a valid/ready handshake. The block arbitrates, drives the decoder input, waits the decoder's fixed latency, captures the decoded result and error flag, and returns them on a single tagged response channel. It sits between the user-project I/O front end and the decoder core.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DEC_LAT`, default 2: decoder input-to-output latency in cycles, ≥1.
- `OUT_W`, default 4: decoded data width.

- `wb_clk_i`  in  1  single clock for the block.
- `wb_rst_i`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_code`  in  NREQ*7  packed code words; requester i uses bits [7i+6:7i].
- `req_ready`  out  NREQ  one-hot accept strobe.
- `dec_in`  out  7  registered decoder input.
- `dec_out`  in  OUT_W  decoder result.
- `dec_err`  in  1  decoder error flag.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  clog2(NREQ)  index of the requester the response belongs to.
- `rsp_data`  out  OUT_W  captured `dec_out`.
- `rsp_err`  out  1  captured `dec_err`.
- `rsp_ready`  in  1  response consumer ready.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any `req_valid` is high, the arbiter picks winner w.
  - `req_ready[w]`=1 combinationally in that cycle. The handshake completes because valid is already high.
  - At the clock edge: `dec_in`←code[w], the id register←w, the latency counter←DEC_LAT−1, next state WAIT.
- WAIT: the counter decrements each cycle. When the counter is 0, `rsp_data`/`rsp_err` capture `dec_out`/`dec_err` at that edge, `rsp_valid`←1, next state RESP.
- RESP: hold `rsp_*` stable until `rsp_valid && rsp_ready`. At that edge `rsp_valid`←0 and the next state is IDLE.
- `req_ready` is 0 in WAIT, in RESP and while `wb_rst_i` is high.
- Once asserted, a requester keeps `req_valid` and its code stable until accepted. A valid withdrawn before acceptance is simply not granted.
- `dec_in` holds the last issued code until the next issue; it does not return to 0.
- Reset values: `req_ready`=0, `dec_in`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, state IDLE, RR pointer 0.
- Reset mid-operation drops the in-flight request; no response is ever issued for it.

## Timing
- Accept in cycle T → `dec_in` valid from T+1 → decoder sampled at the end of cycle T+DEC_LAT → `rsp_valid` high from T+DEC_LAT+1.
- With `rsp_ready` held high: `rsp_valid` lasts 1 cycle and IDLE is reached at T+DEC_LAT+2, so the next accept can occur no earlier than T+DEC_LAT+2.
- `rsp_ready` low stalls indefinitely in RESP. No new request is accepted during a stall.
- Requests arriving during WAIT/RESP wait. They are arbitrated in the first IDLE cycle.

## Configuration
- `DECODER_SCHED_RR_EN` defined: round-robin arbitration.
  - The search starts at the pointer, which is set to w+1 (wrapping from NREQ−1 to 0) at each grant.
  - A requester holding valid is granted within NREQ transactions.
- Undefined: fixed priority, lowest index wins. The pointer logic is not synthesized.

## Structure
- `decoder_sched_pkg`:
  - `CODE_W`=7.
  - FSM state enum (IDLE, WAIT, RESP).
  - id width function.
- Sub-module `decoder_sched_arb`: combinational grant plus pointer register, selected by `DECODER_SCHED_RR_EN`. The top level holds the FSM, counter and datapath registers.

## Test plan
The bench decoder model is `dec_out`=`dec_in[6:3]`, `dec_err`=^`dec_in`, with DEC_LAT=2.
- Single request: req 0 code 7'b1001101 at T, `rsp_ready`=1 → `req_ready`=4'b0001 at T; `dec_in`=7'b1001101 at T+1; `rsp_valid`=1, `rsp_id`=0, `rsp_data`=4'h9, `rsp_err`=0 at T+3.
- Parity error: req 2 code 7'b1001100 → `rsp_id`=2, `rsp_data`=4'h9, `rsp_err`=1.
- Contention: all four valid continuously.
  - RR build: grants 0,1,2,3,0 at 4-cycle spacing.
  - Fixed-priority build: grants 0,0,0.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_*` stable; `req_ready` stays 0 despite a pending req 1; req 1 is accepted in the cycle after the response handshake edge.
- Reset in WAIT: `wb_rst_i`=1 one cycle after accept → `rsp_valid` is never asserted; all outputs are at reset values the next cycle; `busy`=0.
- RR wrap: last grant to req 3, then req 0 and req 3 both valid → req 0 is granted.
